// File: rtl/fetch_redirect_controller_if.sv
// Instruction-memory fetch port: single-outstanding request/ack handshake.
interface fetch_redirect_controller_if #(
    parameter int unsigned Width = 32
);
    localparam int unsigned InstW = 32;

    logic             inst_mem_req;
    logic [Width-1:0] inst_mem_addr;
    logic             inst_mem_ack;
    logic [InstW-1:0] inst_mem_rd_dat;

    modport master (
        output inst_mem_req,
        output inst_mem_addr,
        input  inst_mem_ack,
        input  inst_mem_rd_dat
    );

    modport slave (
        input  inst_mem_req,
        input  inst_mem_addr,
        output inst_mem_ack,
        output inst_mem_rd_dat
    );
endinterface

// File: rtl/fetch_redirect_controller.sv
// Front-end fetch sequencer: owns the PC, fills IF/ID through a one-entry skid,
// and squashes in-flight fetches on mret/sret/jump/taken-branch redirects.
module fetch_redirect_controller #(
    parameter int unsigned     Width       = 32,
    parameter logic [Width-1:0] ResetVector = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [1:0]                   pc_src,
    input  logic                         stall,
    input  logic [Width-1:0]             branch_target,
    input  logic [Width-1:0]             mepc,
    input  logic [Width-1:0]             sepc,
    fetch_redirect_controller_if.master  mem,
    output logic                         if_valid,
    output logic [Width-1:0]             if_pc,
    output logic [31:0]                  if_instruction,
    output logic                         flush_id
);
    localparam int unsigned InstW = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    logic [1:0]       state, state_n;
    logic [Width-1:0] pc, pc_n;
    logic [Width-1:0] squashed_addr, squashed_addr_n;
    logic [Width-1:0] skid_pc, skid_pc_n;
    logic [InstW-1:0] skid_dat, skid_dat_n;
    logic             if_valid_n;
    logic [Width-1:0] if_pc_n;
    logic [InstW-1:0] if_instruction_n;

    logic             redirect;
    logic             consume;
    logic [Width-1:0] target;
    logic [Width-1:0] pc_inc;

    assign redirect = if_valid & ~stall & (pc_src != 2'b00);
    assign consume  = ~if_valid | ~stall;
    assign flush_id = redirect;
    assign pc_inc   = pc + Width'(4);

    always_comb begin
        case (pc_src)
            2'b01:   target = mepc;
            2'b10:   target = sepc;
            default: target = branch_target;
        endcase
    end

    // Request lines decode straight from registered state so they stay put until ack.
    assign mem.inst_mem_req  = (state == S_BUSY) || (state == S_DRAIN);
    assign mem.inst_mem_addr = (state == S_DRAIN) ? squashed_addr : pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            pc             <= ResetVector;
            squashed_addr  <= ResetVector;
            skid_pc        <= '0;
            skid_dat       <= '0;
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instruction <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            squashed_addr  <= squashed_addr_n;
            skid_pc        <= skid_pc_n;
            skid_dat       <= skid_dat_n;
            if_valid       <= if_valid_n;
            if_pc          <= if_pc_n;
            if_instruction <= if_instruction_n;
        end
    end

    always_comb begin
        state_n          = state;
        pc_n             = pc;
        squashed_addr_n  = squashed_addr;
        skid_pc_n        = skid_pc;
        skid_dat_n       = skid_dat;
        if_valid_n       = if_valid;
        if_pc_n          = if_pc;
        if_instruction_n = if_instruction;

        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_n       = target;
                    if_valid_n = 1'b0;
                    state_n    = S_BUSY;
                end else if (consume) begin
                    if_valid_n = 1'b0;
                    state_n    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (redirect) begin
                    // Unacked fetch must still complete; remember its address for the drain.
                    pc_n       = target;
                    if_valid_n = 1'b0;
                    if (!mem.inst_mem_ack) begin
                        squashed_addr_n = pc;
                        state_n         = S_DRAIN;
                    end
                end else if (mem.inst_mem_ack && consume) begin
                    if_pc_n          = pc;
                    if_instruction_n = mem.inst_mem_rd_dat;
                    if_valid_n       = 1'b1;
                    pc_n             = pc_inc;
                end else if (mem.inst_mem_ack) begin
                    skid_pc_n  = pc;
                    skid_dat_n = mem.inst_mem_rd_dat;
                    pc_n       = pc_inc;
                    state_n    = S_FULL;
                end else if (consume) begin
                    if_valid_n = 1'b0;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_n = target;
                end
                if (consume) begin
                    if_valid_n = 1'b0;
                end
                if (mem.inst_mem_ack) begin
                    state_n = S_BUSY;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    skid_pc_n  = '0;
                    skid_dat_n = '0;
                    pc_n       = target;
                    if_valid_n = 1'b0;
                    state_n    = S_BUSY;
                end else if (consume) begin
                    if_pc_n          = skid_pc;
                    if_instruction_n = skid_dat;
                    if_valid_n       = 1'b1;
                    state_n          = S_BUSY;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Directed cycle-by-cycle vectors for the fetch/redirect controller plus a PC wrap sequence.
module tb_fetch_redirect_controller;
    logic        clock;
    logic        reset;
    logic [1:0]  pc_src;
    logic        stall;
    logic [31:0] branch_target;
    logic [31:0] mepc;
    logic [31:0] sepc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        flush_id;

    logic        w_reset;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instruction;
    logic        w_flush_id;

    int compared;
    int mismatched;

    fetch_redirect_controller_if #(.Width(32)) bus ();
    fetch_redirect_controller_if #(.Width(32)) w_bus ();

    fetch_redirect_controller #(.Width(32), .ResetVector(32'h0000_0100)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_src         (pc_src),
        .stall          (stall),
        .branch_target  (branch_target),
        .mepc           (mepc),
        .sepc           (sepc),
        .mem            (bus),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .flush_id       (flush_id)
    );

    fetch_redirect_controller #(.Width(32), .ResetVector(32'hFFFF_FFFC)) dut_wrap (
        .clock          (clock),
        .reset          (w_reset),
        .pc_src         (2'b00),
        .stall          (1'b0),
        .branch_target  (32'h0),
        .mepc           (32'h0),
        .sepc           (32'h0),
        .mem            (w_bus),
        .if_valid       (w_if_valid),
        .if_pc          (w_if_pc),
        .if_instruction (w_if_instruction),
        .flush_id       (w_flush_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        stl;
        logic [1:0]  src;
        logic [31:0] bt;
        logic        ack;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_flush;
        logic        all;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] src,
                                input logic [31:0] bt, input logic ack, input logic [31:0] dat,
                                input logic e_req, input logic [31:0] e_addr, input logic e_val,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic e_flush, input logic all);
        vec_t v;
        v.rst = rst; v.stl = stl; v.src = src; v.bt = bt; v.ack = ack; v.dat = dat;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_flush = e_flush; v.all = all;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b1;
        w_reset       = 1'b1;
        pc_src        = 2'b00;
        stall         = 1'b0;
        branch_target = 32'h0;
        mepc          = 32'h0000_0080;
        sepc          = 32'h0000_0040;
        bus.inst_mem_ack      = 1'b0;
        bus.inst_mem_rd_dat   = 32'h0;
        w_bus.inst_mem_ack    = 1'b0;
        w_bus.inst_mem_rd_dat = 32'h0;

        //           rst stl src bt          ack dat           req addr         val pc           inst          fl all
        vecs[0]  = mk(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h100, 0, 32'h0,   32'h0,        0, 1);
        vecs[1]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        0, 32'h100, 0, 32'h0,   32'h0,        0, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,   1, 32'hA000_0000, 1, 32'h100, 0, 32'h0,   32'h0,        0, 0);
        vecs[3]  = mk(0, 0, 0, 32'h0,   1, 32'hA000_0001, 1, 32'h104, 1, 32'h100, 32'hA000_0000, 0, 0);
        vecs[4]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h108, 1, 32'h104, 32'hA000_0001, 0, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h108, 0, 32'h0,   32'h0,        0, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h108, 0, 32'h0,   32'h0,        0, 0);
        vecs[7]  = mk(0, 0, 0, 32'h0,   1, 32'hA000_0002, 1, 32'h108, 0, 32'h0,   32'h0,        0, 0);
        vecs[8]  = mk(0, 0, 3, 32'h200, 0, 32'h0,        1, 32'h10C, 1, 32'h108, 32'hA000_0002, 1, 0);
        vecs[9]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h10C, 0, 32'h0,   32'h0,        0, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h10C, 0, 32'h0,   32'h0,        0, 0);
        vecs[11] = mk(0, 0, 0, 32'h0,   1, 32'hB000_0000, 1, 32'h200, 0, 32'h0,   32'h0,        0, 0);
        vecs[12] = mk(0, 0, 1, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h204, 1, 32'h200, 32'hB000_0000, 1, 0);
        vecs[13] = mk(0, 0, 0, 32'h0,   1, 32'hC000_0000, 1, 32'h080, 0, 32'h0,   32'h0,        0, 0);
        vecs[14] = mk(0, 0, 2, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h084, 1, 32'h080, 32'hC000_0000, 1, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,   1, 32'hD000_0000, 1, 32'h040, 0, 32'h0,   32'h0,        0, 0);
        vecs[16] = mk(0, 1, 0, 32'h0,   1, 32'hD000_0001, 1, 32'h044, 1, 32'h040, 32'hD000_0000, 0, 0);
        vecs[17] = mk(0, 1, 0, 32'h0,   0, 32'h0,        0, 32'h0,   1, 32'h040, 32'hD000_0000, 0, 0);
        vecs[18] = mk(0, 1, 3, 32'h300, 0, 32'h0,        0, 32'h0,   1, 32'h040, 32'hD000_0000, 0, 0);
        vecs[19] = mk(0, 1, 0, 32'h0,   0, 32'h0,        0, 32'h0,   1, 32'h040, 32'hD000_0000, 0, 0);
        vecs[20] = mk(0, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   1, 32'h040, 32'hD000_0000, 0, 0);
        vecs[21] = mk(0, 0, 0, 32'h0,   1, 32'hD000_0002, 1, 32'h048, 1, 32'h044, 32'hD000_0001, 0, 0);
        vecs[22] = mk(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h04C, 1, 32'h048, 32'hD000_0002, 0, 0);
        vecs[23] = mk(1, 0, 0, 32'h0,   0, 32'h0,        1, 32'h04C, 0, 32'h0,   32'h0,        0, 0);
        vecs[24] = mk(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h100, 0, 32'h0,   32'h0,        0, 1);

        repeat (2) @(posedge clock);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            reset               = vecs[i].rst;
            stall               = vecs[i].stl;
            pc_src              = vecs[i].src;
            branch_target       = vecs[i].bt;
            bus.inst_mem_ack    = vecs[i].ack;
            bus.inst_mem_rd_dat = vecs[i].dat;
            #1;
            check($sformatf("v%0d req", i), 32'(bus.inst_mem_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d valid", i), 32'(if_valid), 32'(vecs[i].e_val));
            check($sformatf("v%0d flush", i), 32'(flush_id), 32'(vecs[i].e_flush));
            if (vecs[i].e_req || vecs[i].all)
                check($sformatf("v%0d addr", i), bus.inst_mem_addr, vecs[i].e_addr);
            if (vecs[i].e_val || vecs[i].all) begin
                check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
                check($sformatf("v%0d if_inst", i), if_instruction, vecs[i].e_inst);
            end
        end

        // PC wrap: reset vector at the top of the address space rolls over to 0.
        @(negedge clock);
        w_reset = 1'b0;
        #1;
        check("wrap idle req", 32'(w_bus.inst_mem_req), 32'd0);
        check("wrap idle addr", w_bus.inst_mem_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        w_bus.inst_mem_ack    = 1'b1;
        w_bus.inst_mem_rd_dat = 32'h1111_1111;
        #1;
        check("wrap req", 32'(w_bus.inst_mem_req), 32'd1);
        check("wrap addr0", w_bus.inst_mem_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        w_bus.inst_mem_rd_dat = 32'h2222_2222;
        #1;
        check("wrap addr1", w_bus.inst_mem_addr, 32'h0000_0000);
        check("wrap valid1", 32'(w_if_valid), 32'd1);
        check("wrap if_pc1", w_if_pc, 32'hFFFF_FFFC);
        check("wrap inst1", w_if_instruction, 32'h1111_1111);
        @(negedge clock);
        w_bus.inst_mem_ack = 1'b0;
        #1;
        check("wrap addr2", w_bus.inst_mem_addr, 32'h0000_0004);
        check("wrap if_pc2", w_if_pc, 32'h0000_0000);
        check("wrap inst2", w_if_instruction, 32'h2222_2222);
        check("wrap flush", 32'(w_flush_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_controller.md
# fetch_redirect_controller

Sequences instruction fetch and PC redirection for the core front end. Owns the PC register, issues single-outstanding requests to instruction memory, fills the IF/ID register, and applies the `pc_src` decision from the branch decoder unit. On a redirect (mret, sret, jump or taken conditional branch) it flushes IF/ID and squashes any in-flight fetch.

## Interface
- `Width`, 32, address/PC width in bits.
- `ResetVector`, 0, PC value after reset.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_src`  in  2  decision from the branch decoder for the instruction in IF/ID:
  - 00 sequential
  - 01 `mepc`
  - 10 `sepc`
  - 11 `branch_target`
- `stall`  in  1  hazard stall from decode; IF/ID must hold.
- `branch_target`  in  Width  jump or branch target.
- `mepc`, `sepc`  in  Width  trap return addresses.
- `inst_mem_ack`  in  1  memory accepted and completed the current request; data is valid this cycle.
- `inst_mem_rd_dat`  in  32  fetched instruction.
- `inst_mem_req`  out  1  fetch request.
- `inst_mem_addr`  out  Width  fetch address.
- `if_valid`  out  1  IF/ID holds a valid instruction.
- `if_pc`  out  Width  PC of the IF/ID instruction.
- `if_instruction`  out  32  IF/ID instruction.
- `flush_id`  out  1  combinational; high in the cycle a redirect is taken.

## Operation
- `redirect = if_valid & ~stall & (pc_src != 2'b00)`. A redirect has priority over every other event.
- `consume = ~if_valid | ~stall`: the IF/ID slot can accept data at the next edge.
- FSM states:
  - **Idle**: `inst_mem_req=0`.
    - If `consume` or a redirect: go to Busy next cycle.
    - Otherwise stay.
  - **Busy**: `inst_mem_req=1`, `inst_mem_addr=pc`.
    - `redirect & ~ack`: `pc<=target`, `if_valid<=0`, go to Drain.
    - `redirect & ack`: discard data, `pc<=target`, `if_valid<=0`, stay Busy.
    - `ack & consume`: IF/ID <= {`pc`, `rd_dat`}, `if_valid<=1`, `pc<=pc+4`, stay Busy.
    - `ack & ~consume`: data goes to the skid register, `pc<=pc+4`, go to Full.
    - Otherwise hold; `req` and `addr` stay stable.
  - **Drain**: `inst_mem_req=1`, `inst_mem_addr=squashed_addr`, a register captured at redirect.
    - On ack: discard data, go to Busy at the new `pc`.
    - A further redirect while in Drain updates `pc` only.
  - **Full**: `inst_mem_req=0`.
    - On `consume`: IF/ID <= skid, `if_valid<=1`, go to Busy.
    - On redirect: clear skid, `pc<=target`, `if_valid<=0`, go to Busy.
- When a redirect is taken and not stalled, the consumed instruction leaves IF/ID. If `consume` occurs with no new data, `if_valid<=0`.
- Target select: 01→`mepc`, 10→`sepc`, 11→`branch_target`. Targets are used unmodified; no alignment check.
- PC increment is +4 modulo 2^Width; 0xFFFF_FFFC wraps to 0.
- Handshake rule: once `inst_mem_req` is asserted, `req` and `addr` are held until the ack cycle. The address may change in the cycle after an ack.
- At most one request is outstanding. Squashed data never reaches IF/ID.

## Timing
- Reset values:
  - `inst_mem_req=0`, `inst_mem_addr=ResetVector`
  - `if_valid=0`, `if_pc=0`, `if_instruction=0`
  - `flush_id=0`, skid empty, `pc=ResetVector`, state Idle
- First request is asserted in the first cycle after `reset` deasserts.
- Latency: ack in cycle N gives `if_valid=1` with that data in cycle N+1.
- Zero-wait memory (ack every cycle) sustains one instruction per cycle.
- Redirect taken in cycle N:
  - With ack in N: the first request to the target is in N+1.
  - Without ack in N: the target request starts the cycle after the drain ack.
- Reset mid-operation drops `req` at the next edge, including an outstanding request. Memory shares the same reset.
- `flush_id` depends only on current inputs and state; no register delay.

## Test plan
- **Reset, zero-wait memory:** `ResetVector=0x100`, ack every cycle, no stall → addresses 0x100, 0x104, 0x108 on consecutive cycles; `if_pc` trails `inst_mem_addr` by one cycle.
- **Wait states:** ack delayed 3 cycles → `req=1` and `addr=0x100` stable for all 4 cycles; single `if_valid` pulse per fetch.
- **Redirect during outstanding fetch:**
  - Setup: `pc_src=11`, `branch_target=0x200`, ack 2 cycles later.
  - Required: `flush_id=1` for one cycle and `if_valid` falls.
  - Required: the old address is held until ack and its data is dropped; next request is at 0x200 with `if_pc=0x200`.
- **mret/sret with ack in the same cycle:** `pc_src=01` with `mepc=0x80`, ack present → data discarded; next request is at 0x80. Repeat with `pc_src=10`, `sepc=0x40`.
- **Stall and skid:** hold `stall` for 4 cycles while a fetch acks → state Full and `req=0`. On release, the skid instruction appears in IF/ID with the correct PC, then fetch resumes at PC+4 with no lost or duplicated instruction.
- **Wrap and mid-operation reset:**
  - Start at 0xFFFF_FFFC → next address is 0x0.
  - Assert `reset` with a request outstanding → all outputs return to reset values on the next edge.
